// File: rtl/dc_ram_fifo_pkg.sv
// Shared sizing helpers and types for the dc_ram-backed FIFO controller.
package dc_ram_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  function automatic int cnt_width(input int aw);
    return aw + 2;
  endfunction

  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  typedef logic [DEF_ADDR_WIDTH:0] def_ptr_t;
  typedef logic [1:0]              obuf_cnt_t;

endpackage

// File: rtl/dc_ram_fifo_ctrl_out_buf.sv
// Two-entry registered FIFO that absorbs the RAM read latency; entry 0 is always the head.
module fifo_out_buf
  import dc_ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output obuf_cnt_t             cnt_o
);

  logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  obuf_cnt_t             cnt_q, cnt_d;

  // Popping the last entry leaves entry 0 untouched so the head keeps its old value.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = data_i;
          else               e1_d = data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) e0_d = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = data_i;
          end else begin
            e0_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = e0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/dc_ram_fifo_ctrl.sv
// Single-clock FIFO controller using an external dual-port RAM plus a 2-entry output buffer.
module dc_ram_fifo_ctrl
  import dc_ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clr_i,
  input  logic [DATA_WIDTH-1:0]              s_data_i,
  input  logic                               s_valid_i,
  output logic                               s_ready_o,
  output logic [DATA_WIDTH-1:0]              m_data_o,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic [cnt_width(ADDR_WIDTH)-1:0]   count_o,
  output logic [DATA_WIDTH-1:0]              ram_data_a_o,
  output logic [ADDR_WIDTH-1:0]              ram_addr_a_o,
  output logic                               ram_we_a_o,
  output logic [ADDR_WIDTH-1:0]              ram_addr_b_o,
  input  logic [DATA_WIDTH-1:0]              ram_q_b_i
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int PW    = ptr_width(ADDR_WIDTH);
  localparam int CW    = cnt_width(ADDR_WIDTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic          push, pop, issue;
  logic [2:0]    occ_next;
  obuf_cnt_t     obuf_cnt;

  assign ram_cnt   = wr_ptr_q - rd_ptr_q;
  assign s_ready_o = (ram_cnt != PW'(DEPTH));
  assign push      = s_valid_i & s_ready_o & ~clr_i;
  assign pop       = m_valid_o & m_ready_i;

  // Buffer occupancy after this cycle if nothing new is issued; a new read needs a free slot.
  assign occ_next = {1'b0, obuf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue    = (ram_cnt != '0) & ~clr_i & (occ_next < 3'd2);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{(PW-1){1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, issue};
    inflight_d = issue;
    count_d    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    if (clr_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  fifo_out_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_buf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr_i),
    .push_i (inflight_q),
    .data_i (ram_q_b_i),
    .pop_i  (pop),
    .data_o (m_data_o),
    .valid_o(m_valid_o),
    .cnt_o  (obuf_cnt)
  );

  assign ram_data_a_o = s_data_i;
  assign ram_addr_a_o = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_we_a_o   = push;
  assign ram_addr_b_o = rd_ptr_q[ADDR_WIDTH-1:0];
  assign count_o      = count_q;

endmodule

// File: tb/tb_dc_ram_fifo_ctrl.sv
// Directed bench for dc_ram_fifo_ctrl with a behavioural 16-deep dual-port RAM alongside.
module tb_dc_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, clr, s_valid, m_ready;
  logic [DW-1:0] s_data;
  logic          s_ready, m_valid, ram_we_a;
  logic [DW-1:0] m_data, ram_data_a, ram_q_b;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_addr_a, ram_addr_b;

  logic [DW-1:0] mem [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Storage model: synchronous write on port A, registered read on port B.
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  dc_ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clr_i       (clr),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .count_o     (count),
    .ram_data_a_o(ram_data_a),
    .ram_addr_a_o(ram_addr_a),
    .ram_we_a_o  (ram_we_a),
    .ram_addr_b_o(ram_addr_b),
    .ram_q_b_i   (ram_q_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    tick();
    total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); end
    total++; if (count !== 6'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_s_ready: got %b want 1", s_ready); end
    total++; if (ram_we_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_we_a: got %b want 0", ram_we_a); end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    logic [5:0] ec [5];
    logic       em [5];
    ec = '{6'd0, 6'd1, 6'd1, 6'd1, 6'd0};
    em = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      total++; if (count !== ec[k]) begin bad++; $display("[TB] FAIL single_count[%0d]: got %0d want %0d", k, count, ec[k]); end
      total++; if (m_valid !== em[k]) begin bad++; $display("[TB] FAIL single_m_valid[%0d]: got %b want %b", k, m_valid, em[k]); end
      if (k == 3) begin
        total++; if (m_data !== 8'hA5) begin bad++; $display("[TB] FAIL single_m_data: got %h want a5", m_data); end
      end
      m_ready = 1'b1;
      s_valid = (k == 0);
      s_data  = (k == 0) ? 8'hA5 : 8'h00;
      if (k == 0) begin
        #1;
        total++; if (ram_we_a !== 1'b1 || ram_data_a !== 8'hA5) begin bad++; $display("[TB] FAIL single_ram_write: got we=%b data=%h want we=1 data=a5", ram_we_a, ram_data_a); end
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_fill;
    int acc = 0;
    int exp = 0;
    int gaps = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      if (s_ready) acc++;
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    total++; if (acc != 18) begin bad++; $display("[TB] FAIL fill_accepted: got %0d want 18", acc); end
    total++; if (count !== 6'd18) begin bad++; $display("[TB] FAIL fill_count: got %0d want 18", count); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_s_ready: got %b want 0", s_ready); end
    m_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 0) begin
        total++; if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_s_ready_before_issue: got %b want 0", s_ready); end
      end
      if (c == 1) begin
        total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL fill_s_ready_after_issue: got %b want 1", s_ready); end
      end
      if (m_valid) begin
        total++; if (m_data !== 8'(exp)) begin bad++; $display("[TB] FAIL fill_data[%0d]: got %h want %h", exp, m_data, 8'(exp)); end
        exp++;
      end else if (exp > 0 && exp < 18) begin
        gaps++;
      end
      tick();
    end
    total++; if (exp != 18) begin bad++; $display("[TB] FAIL fill_drained: got %0d want 18", exp); end
    total++; if (gaps != 0) begin bad++; $display("[TB] FAIL fill_gaps: got %0d want 0", gaps); end
    total++; if (count !== 6'd0) begin bad++; $display("[TB] FAIL fill_count_empty: got %0d want 0", count); end
  endtask

  task automatic test_streaming;
    logic [DW-1:0] sb [$];
    int rcv = 0;
    for (int k = 0; k < 100; k++) begin
      if (k >= 3) begin
        total++; if (count !== 6'd3) begin bad++; $display("[TB] FAIL stream_count[%0d]: got %0d want 3", k, count); end
        total++; if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_m_valid[%0d]: got %b want 1", k, m_valid); end
      end
      if (m_valid) begin
        if (sb.size() == 0) begin
          total++; bad++; $display("[TB] FAIL stream_spurious[%0d]: got %h want nothing", k, m_data);
        end else begin
          total++; if (m_data !== sb[0]) begin bad++; $display("[TB] FAIL stream_data[%0d]: got %h want %h", k, m_data, sb[0]); end
          void'(sb.pop_front());
          rcv++;
        end
      end
      s_valid = 1'b1;
      s_data  = 8'(k + 64);
      m_ready = 1'b1;
      if (s_ready) sb.push_back(s_data);
      tick();
    end
    s_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (m_valid && sb.size() != 0) begin
        total++; if (m_data !== sb[0]) begin bad++; $display("[TB] FAIL stream_tail_data: got %h want %h", m_data, sb[0]); end
        void'(sb.pop_front());
        rcv++;
      end
      tick();
    end
    total++; if (rcv != 100) begin bad++; $display("[TB] FAIL stream_received: got %0d want 100", rcv); end
    total++; if (count !== 6'd0) begin bad++; $display("[TB] FAIL stream_count_empty: got %0d want 0", count); end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] sb [$];
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    while (rcv < 40 && cyc < 2000) begin
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          total++; bad++; $display("[TB] FAIL wrap_spurious: got %h want nothing", m_data);
        end else begin
          total++; if (m_data !== sb[0]) begin bad++; $display("[TB] FAIL wrap_data[%0d]: got %h want %h", rcv, m_data, sb[0]); end
          void'(sb.pop_front());
        end
        rcv++;
      end
      s_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
      s_data  = 8'(8'h80 + sent);
      m_ready = ($urandom_range(0, 2) != 0);
      if (s_valid && s_ready) begin
        sb.push_back(s_data);
        sent++;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    total++; if (rcv != 40) begin bad++; $display("[TB] FAIL wrap_received: got %0d want 40", rcv); end
    total++; if (count !== 6'd0) begin bad++; $display("[TB] FAIL wrap_count_empty: got %0d want 0", count); end
  endtask

  task automatic test_clr;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h50 + i);
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    total++; if (count !== 6'd10) begin bad++; $display("[TB] FAIL clr_prefill_count: got %0d want 10", count); end
    total++; if (m_data !== 8'h50) begin bad++; $display("[TB] FAIL clr_prefill_head: got %h want 50", m_data); end
    m_ready = 1'b1;
    tick();
    total++; if (count !== 6'd9) begin bad++; $display("[TB] FAIL clr_after_pop_count: got %0d want 9", count); end
    m_ready = 1'b0;
    clr     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    tick();
    clr     = 1'b0;
    s_valid = 1'b0;
    total++; if (count !== 6'd0) begin bad++; $display("[TB] FAIL clr_count: got %0d want 0", count); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL clr_m_valid: got %b want 0", m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL clr_s_ready: got %b want 1", s_ready); end
    s_valid = 1'b1;
    s_data  = 8'h3C;
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int j = 0; j < 3 && !m_valid; j++) tick();
    total++; if (m_valid !== 1'b1 || m_data !== 8'h3C) begin bad++; $display("[TB] FAIL clr_next_word: got valid=%b data=%h want valid=1 data=3c", m_valid, m_data); end
    tick();
    total++; if (count !== 6'd0 || m_valid !== 1'b0) begin bad++; $display("[TB] FAIL clr_no_leftover: got count=%0d valid=%b want count=0 valid=0", count, m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_rst_mid;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1;
      s_data  = 8'(k);
      m_ready = 1'b1;
      tick();
    end
    #3 rst = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_m_valid: got %b want 0", m_valid); end
    total++; if (count !== 6'd0) begin bad++; $display("[TB] FAIL rst_mid_count: got %0d want 0", count); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_s_ready: got %b want 1", s_ready); end
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    s_valid = 1'b1;
    s_data  = 8'h77;
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    total++; if (m_valid !== 1'b1 || m_data !== 8'h77) begin bad++; $display("[TB] FAIL rst_resume_data: got valid=%b data=%h want valid=1 data=77", m_valid, m_data); end
    total++; if (count !== 6'd1) begin bad++; $display("[TB] FAIL rst_resume_count: got %0d want 1", count); end
    tick();
    total++; if (count !== 6'd0) begin bad++; $display("[TB] FAIL rst_resume_empty: got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_streaming();
    test_wrap();
    test_clr();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
